// File: rtl/ob_pkg.sv
// Shared order-book quantity and tag types for the count request path.
package ob_pkg;

    localparam int QUANTITY_W = 16;
    localparam int ACCUM_W    = 24;
    localparam int UID_W      = 8;

    typedef logic [QUANTITY_W-1:0] quantity_t;
    typedef logic [ACCUM_W-1:0]    accum_quantity_t;
    typedef logic [UID_W-1:0]      uid_t;

    // Zero-extends a goal so it compares against an accumulated count.
    function automatic accum_quantity_t widen_quantity(input quantity_t q);
        return accum_quantity_t'(q);
    endfunction

endpackage

// File: rtl/ob_mk_cnt_req_if.sv
// Query/response handshake plus the count-engine side-band for ob_mk_cnt_req.
interface ob_mk_cnt_req_if;
    import ob_pkg::*;

    logic            req_vld;
    logic            req_rdy;
    quantity_t       req_quantity;
    uid_t            req_uid;
    logic            rsp_vld;
    logic            rsp_rdy;
    accum_quantity_t rsp_quantity;
    logic            rsp_ok;
    logic            rsp_err;
    uid_t            rsp_uid;
    logic            cnt_cmd_vld;
    logic            cnt_busy;
    accum_quantity_t cnt_rsp_quantity;

    modport slave (
        input  req_vld, req_quantity, req_uid, rsp_rdy, cnt_busy, cnt_rsp_quantity,
        output req_rdy, rsp_vld, rsp_quantity, rsp_ok, rsp_err, rsp_uid, cnt_cmd_vld
    );

    modport master (
        output req_vld, req_quantity, req_uid, rsp_rdy, cnt_busy, cnt_rsp_quantity,
        input  req_rdy, rsp_vld, rsp_quantity, rsp_ok, rsp_err, rsp_uid, cnt_cmd_vld
    );

endinterface

// File: rtl/ob_mk_cnt_req.sv
// Issues one count command per query, waits for the engine, and reports count >= goal.
// Optional wait timeout with drain is enabled by defining OB_MK_CNT_REQ_TIMEOUT_EN.
module ob_mk_cnt_req
    import ob_pkg::*;
#(
    parameter int unsigned TIMEOUT_N = 64
) (
    input  logic           clk,
    input  logic           rst,
    ob_mk_cnt_req_if.slave bus
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

    state_t          r_state;
    state_t          w_state_next;
    quantity_t       r_goal;
    uid_t            r_uid;
    accum_quantity_t r_rsp_quantity;
    logic            r_rsp_ok;
    logic            w_req_rdy;
    logic            w_accept;
    logic            w_capture;

    generate
        if (TIMEOUT_N < 1) begin : g_bad_timeout
            $error("ob_mk_cnt_req: TIMEOUT_N must be at least 1");
        end
    endgenerate

`ifdef OB_MK_CNT_REQ_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_N + 1);

    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_rsp_err;
    logic              w_timeout;
`endif

    // A still-busy engine in IDLE means a previous command has not drained yet.
    assign w_req_rdy = (r_state == IDLE) && !bus.cnt_busy && !rst;
    assign w_accept  = bus.req_vld && w_req_rdy;

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
`ifdef OB_MK_CNT_REQ_TIMEOUT_EN
        w_timeout    = 1'b0;
`endif
        case (r_state)
            IDLE:  if (w_accept) w_state_next = ISSUE;
            ISSUE: w_state_next = WAIT;
            WAIT: begin
                if (!bus.cnt_busy) begin
                    w_capture    = 1'b1;
                    w_state_next = RESP;
                end
`ifdef OB_MK_CNT_REQ_TIMEOUT_EN
                else if (r_wait_cnt == WAIT_W'(TIMEOUT_N - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = RESP;
                end
`endif
            end
            RESP: begin
                if (bus.rsp_rdy) begin
`ifdef OB_MK_CNT_REQ_TIMEOUT_EN
                    w_state_next = r_rsp_err ? DRAIN : IDLE;
`else
                    w_state_next = IDLE;
`endif
                end
            end
            DRAIN:   if (!bus.cnt_busy) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_goal         <= '0;
            r_uid          <= '0;
            r_rsp_quantity <= '0;
            r_rsp_ok       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_goal <= bus.req_quantity;
                r_uid  <= bus.req_uid;
            end
            if (w_capture) begin
                r_rsp_quantity <= bus.cnt_rsp_quantity;
                r_rsp_ok       <= (widen_quantity(r_goal) <= bus.cnt_rsp_quantity);
            end
`ifdef OB_MK_CNT_REQ_TIMEOUT_EN
            if (w_timeout) begin
                r_rsp_quantity <= '0;
                r_rsp_ok       <= 1'b0;
            end
`endif
        end
    end

`ifdef OB_MK_CNT_REQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (r_state == ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if (w_capture) begin
                r_rsp_err <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    assign bus.rsp_err = r_rsp_err;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // Command pulse decodes purely from state so it never loops through cnt_busy.
    assign bus.req_rdy      = w_req_rdy;
    assign bus.cnt_cmd_vld  = (r_state == ISSUE);
    assign bus.rsp_vld      = (r_state == RESP);
    assign bus.rsp_quantity = r_rsp_quantity;
    assign bus.rsp_ok       = r_rsp_ok;
    assign bus.rsp_uid      = r_uid;

endmodule

// File: doc/ob_mk_cnt_req.md
OB_MK_CNT_REQ -- requirements
Module: ob_mk_cnt_req

Interface
REQ-001 Parameter TIMEOUT_N, default 64, SHALL set the maximum cycles spent waiting for the count engine before an error response.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the reset; asynchronous, active-high.
REQ-004 req_vld  input  1  SHALL indicate a valid query.
REQ-005 req_rdy  output  1  SHALL indicate the block accepts a query this cycle.
REQ-006 req_quantity  input  ob_pkg::quantity_t  SHALL carry the goal quantity.
REQ-007 req_uid  input  ob_pkg::uid_t  SHALL carry the query tag.
REQ-008 rsp_vld  output  1  SHALL indicate a valid response.
REQ-009 rsp_rdy  input  1  SHALL indicate the consumer accepts the response.
REQ-010 rsp_quantity  output  ob_pkg::accum_quantity_t  SHALL carry the captured count.
REQ-011 rsp_ok  output  1  SHALL be set when rsp_quantity >= goal.
REQ-012 rsp_err  output  1  SHALL be set on timeout.
REQ-013 rsp_uid  output  ob_pkg::uid_t  SHALL echo req_uid.
REQ-014 cnt_cmd_vld  output  1  SHALL be the command pulse to the count engine (ob_mk_table_cnt).
REQ-015 cnt_busy  input  1  SHALL be the engine busy flag (combinational in cnt_cmd_vld).
REQ-016 cnt_rsp_quantity  input  ob_pkg::accum_quantity_t  SHALL be the engine result.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, RESP, DRAIN.
REQ-018 req_rdy SHALL be 1 only in IDLE; req_vld & req_rdy SHALL latch quantity/uid and go to ISSUE.
REQ-019 cnt_cmd_vld SHALL decode from state register only (ISSUE), never from cnt_busy, avoiding a combinational loop.
REQ-020 ISSUE SHALL last exactly one cycle, then WAIT; the wait counter SHALL clear on ISSUE.
REQ-021 In WAIT, first cycle with cnt_busy=0 SHALL capture cnt_rsp_quantity, compute rsp_ok, clear rsp_err, go RESP.
REQ-022 Compare SHALL zero-extend goal to accum_quantity_t width; equal SHALL give rsp_ok=1.
REQ-023 RESP SHALL hold rsp_vld=1 and stable outputs until rsp_rdy; on rsp_rdy go IDLE.
REQ-024 Back-to-back: rsp accept cycle SHALL not accept a new request; next request earliest the following cycle.
REQ-025 If cnt_busy=1 while in IDLE (engine not drained), req_rdy SHALL be 0.
REQ-026 Output reset values: req_rdy 0 during rst, rsp_vld 0, rsp_ok 0, rsp_err 0, rsp_quantity 0, rsp_uid 0, cnt_cmd_vld 0.

Reset
REQ-027 rst SHALL force IDLE and clear all registers asynchronously, including mid-WAIT or mid-RESP; any pending response SHALL be dropped.

Configuration
REQ-028 With OB_MK_CNT_REQ_TIMEOUT_EN defined: wait counter SHALL count WAIT cycles; reaching TIMEOUT_N with cnt_busy=1 SHALL go RESP with rsp_err=1, rsp_ok=0, rsp_quantity=0; after rsp accept, go DRAIN, remaining until cnt_busy=0, then IDLE.
REQ-029 Without OB_MK_CNT_REQ_TIMEOUT_EN: no counter, DRAIN unreachable, rsp_err tied 0, WAIT unbounded.

Structure
REQ-030 quantity_t, accum_quantity_t, uid_t SHALL come from ob_pkg; FSM encoding SHALL be module-local.
REQ-031 No sub-module; parent SHALL instantiate this block beside ob_mk_table_cnt.

Verification
REQ-032 Goal 100, engine returns 150 after busy -> rsp_vld, rsp_quantity=150, rsp_ok=1, rsp_err=0, uid echoed.
REQ-033 Goal 200, engine returns 200 -> rsp_ok=1; goal 201 -> rsp_ok=0.
REQ-034 rsp_rdy held 0 for 5 cycles -> outputs stable, req_rdy=0, cnt_cmd_vld single one-cycle pulse.
REQ-035 TIMEOUT_EN, TIMEOUT_N=8, cnt_busy stuck 1 -> rsp_err=1 after 8 WAIT cycles; req_rdy 0 until busy drops.
REQ-036 rst asserted mid-WAIT -> all outputs 0 immediately; next request after rst completes normally.
REQ-037 Two back-to-back queries, rsp_rdy=1 -> two responses in order, one cnt_cmd_vld pulse each.
